// File: rtl/mips_pkg.sv
// Shared pipeline constants and the stage slot record used by the hazard
// bookkeeping logic.
package mips_pkg;
   localparam int TNEW_W    = 2;
   localparam int REG_W     = 5;
   localparam int TNEW_ALU  = 1;
   localparam int TNEW_LOAD = 2;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_W-1:0]  reg_wa;
      logic [TNEW_W-1:0] tnew;
   } stage_slot_t;
endpackage

// File: rtl/hazard_tnew_tracker_if.sv
// Signal bundle between the D stage / hazard unit and the Tnew tracker.
// Handshake: no valid/ready pair; D_Valid qualifies D_* every cycle and stall is a same-cycle request.
interface hazard_tnew_tracker_if
   import mips_pkg::*;
   #(parameter int CNT_W = 16) ();
   logic              D_Valid;
   logic [TNEW_W-1:0] D_Tnew;
   logic [REG_W-1:0]  D_Reg_WA;
   logic              stall;
   logic [TNEW_W-1:0] E_Tnew;
   logic [REG_W-1:0]  E_Reg_WA;
   logic [TNEW_W-1:0] M_Tnew;
   logic [REG_W-1:0]  M_Reg_WA;
   logic [REG_W-1:0]  W_Reg_WA;
   logic              PC_En;
   logic              FD_En;
   logic              DE_Clr;
   logic [CNT_W-1:0]  Stall_Cnt;
   logic [CNT_W-1:0]  Bubble_Cnt;

   modport master (
      output D_Valid, D_Tnew, D_Reg_WA, stall,
      input  E_Tnew, E_Reg_WA, M_Tnew, M_Reg_WA, W_Reg_WA,
      input  PC_En, FD_En, DE_Clr, Stall_Cnt, Bubble_Cnt
   );

   modport slave (
      input  D_Valid, D_Tnew, D_Reg_WA, stall,
      output E_Tnew, E_Reg_WA, M_Tnew, M_Reg_WA, W_Reg_WA,
      output PC_En, FD_En, DE_Clr, Stall_Cnt, Bubble_Cnt
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/hazard_tnew_tracker.sv
// Keeps the E/M/W destination register and remaining Tnew for the hazard unit,
// and turns the unit's stall into PC/FD freeze plus a DE bubble.
module hazard_tnew_tracker
   import mips_pkg::*;
   #(
   parameter int CNT_W    = 16,
   parameter int TNEW_MAX = TNEW_LOAD
) (
   input  logic                  clk,
   input  logic                  rst_n,
   hazard_tnew_tracker_if.slave  bus
);
   stage_slot_t      e_q, m_q, e_d, m_d;
   logic [REG_W-1:0] w_wa_q;
   logic             bubble;
   logic [CNT_W-1:0] stall_cnt, bubble_cnt;

   always_comb begin
      bubble   = bus.stall | ~bus.D_Valid;
      e_d      = '{reg_wa: REG_ZERO, tnew: '0};
      if (!bubble) begin
         e_d.reg_wa = bus.D_Reg_WA;
         e_d.tnew   = (int'(bus.D_Tnew) > TNEW_MAX) ? TNEW_W'(TNEW_MAX) : bus.D_Tnew;
         // A $0 writer never produces a result anyone waits on.
         if (bus.D_Reg_WA == REG_ZERO) e_d.tnew = '0;
      end
      m_d.reg_wa = e_q.reg_wa;
      m_d.tnew   = (e_q.tnew == '0) ? '0 : e_q.tnew - 1'b1;
      if (e_q.reg_wa == REG_ZERO) m_d.tnew = '0;
   end

   // M and W advance every cycle; only the E slot reacts to stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q    <= '{reg_wa: REG_ZERO, tnew: '0};
         m_q    <= '{reg_wa: REG_ZERO, tnew: '0};
         w_wa_q <= REG_ZERO;
      end else begin
         e_q    <= e_d;
         m_q    <= m_d;
         w_wa_q <= m_q.reg_wa;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bus.stall),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bubble),
      .count (bubble_cnt)
   );

   assign bus.E_Reg_WA   = e_q.reg_wa;
   assign bus.E_Tnew     = (e_q.reg_wa == REG_ZERO) ? '0 : e_q.tnew;
   assign bus.M_Reg_WA   = m_q.reg_wa;
   assign bus.M_Tnew     = (m_q.reg_wa == REG_ZERO) ? '0 : m_q.tnew;
   assign bus.W_Reg_WA   = w_wa_q;
   assign bus.PC_En      = ~bus.stall;
   assign bus.FD_En      = ~bus.stall;
   assign bus.DE_Clr     = bus.stall;
   assign bus.Stall_Cnt  = stall_cnt;
   assign bus.Bubble_Cnt = bubble_cnt;
endmodule
